sr_latch_driver: RTL and testbench

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

---
 rtl/sr_latch_driver.sv | 105 ++++++++++
 tb/tb_sr_latch_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Pulse driver for an external SR latch: dead time, a single-sided pulse, settle time,
// then a readback check against the commanded state, with a saturating error counter.
module sr_latch_driver #(
    parameter int PULSE_W  = 4,
    parameter int DEAD_W   = 2,
    parameter int SETTLE_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_val,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    input  logic       qbar_fb,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        DEAD,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    localparam logic [7:0] DEAD_LAST   = 8'(DEAD_W - 1);
    localparam logic [7:0] PULSE_LAST  = 8'(PULSE_W - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_W - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            target  <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && cmd_valid) begin
                target <= cmd_val;
            end
            if (err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // cnt counts cycles spent in the current timed phase and restarts on every phase change.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 8'd1;
        case (state)
            IDLE: begin
                cnt_next = 8'd0;
                if (cmd_valid) begin
                    state_next = DEAD;
                end
            end
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_next = PULSE;
                    cnt_next   = 8'd0;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_next = SETTLE;
                    cnt_next   = 8'd0;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_next = CHECK;
                    cnt_next   = 8'd0;
                end
            end
            CHECK: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // s and r come only from the PULSE state and one register, so they can never both be high.
    assign s         = (state == PULSE) && target;
    assign r         = (state == PULSE) && !target;
    assign cmd_ready = (state == IDLE) && !rst;
    assign done      = (state == CHECK);
    assign err       = done && ((q_fb != target) || (qbar_fb == target));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: each handshake queues its expected pulse window,
// CHECK cycle and err value; a negedge monitor compares every cycle against the queue head.
module tb_sr_latch_driver;

    localparam int PULSE_W  = 4;
    localparam int DEAD_W   = 2;
    localparam int SETTLE_W = 2;
    localparam int N        = DEAD_W + PULSE_W + SETTLE_W + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmdValid;
    logic       cmdVal;
    logic       cmdReady;
    logic       s;
    logic       r;
    logic       qFb;
    logic       qbarFb;
    logic       done;
    logic       err;
    logic [7:0] errCnt;

    // 0 = healthy latch, 1 = stuck at q=0, 2 = invalid q=qbar=1
    int   mode = 0;
    logic lq   = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   modelCnt = 0;
    logic monOn = 1'b0;

    typedef struct {
        int   start;
        logic val;
        logic expErr;
    } cmd_t;

    cmd_t sb[$];

    sr_latch_driver #(
        .PULSE_W (PULSE_W),
        .DEAD_W  (DEAD_W),
        .SETTLE_W(SETTLE_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmdValid),
        .cmd_val  (cmdVal),
        .cmd_ready(cmdReady),
        .s        (s),
        .r        (r),
        .q_fb     (qFb),
        .qbar_fb  (qbarFb),
        .done     (done),
        .err      (err),
        .err_cnt  (errCnt)
    );

    always #5 clk = ~clk;

    // Behavioural SR latch, with fault modes overriding the readback.
    always @(posedge clk) begin
        if (s) lq <= 1'b1;
        else if (r) lq <= 1'b0;
    end

    assign qFb    = (mode == 0) ? lq : (mode == 1) ? 1'b0 : 1'b1;
    assign qbarFb = (mode == 0) ? ~lq : 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic val);
        cmdValid = valid;
        cmdVal   = val;
    endtask

    // Offer a command until it is accepted; hold keeps cmd_valid high afterwards.
    task automatic sendCmd(input logic val, input logic hold);
        logic got;
        got = 1'b0;
        applyStimulus(1'b1, val);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmdReady) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("handshakeTimeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) applyStimulus(1'b0, ~val);
        else cmdVal = ~val;
    endtask

    task automatic waitIdle();
        repeat (N + 3) @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor: expectations are computed before the queue is updated for this cycle.
    always @(negedge clk) begin
        if (monOn) begin
            logic expS;
            logic expR;
            logic expDone;
            logic atCheck;
            int   p;
            cyc++;
            expS    = 1'b0;
            expR    = 1'b0;
            expDone = 1'b0;
            atCheck = 1'b0;
            if (sb.size() > 0) begin
                p = cyc - sb[0].start;
                if (p >= DEAD_W + 1 && p <= DEAD_W + PULSE_W) begin
                    expS = sb[0].val;
                    expR = !sb[0].val;
                end
                atCheck = (p == N);
                expDone = atCheck;
            end
            checkOutput("s", 32'(s), 32'(expS));
            checkOutput("r", 32'(r), 32'(expR));
            checkOutput("sAndR", 32'(s && r), 32'd0);
            checkOutput("done", 32'(done), 32'(expDone));
            checkOutput("cmdReady", 32'(cmdReady), 32'(!rst && sb.size() == 0));
            checkOutput("errCnt", 32'(errCnt), 32'(modelCnt));
            if (atCheck) begin
                checkOutput("err", 32'(err), 32'(sb[0].expErr));
                if (sb[0].expErr && modelCnt < 255) modelCnt++;
                void'(sb.pop_front());
            end else begin
                checkOutput("errQualified", 32'(err), 32'd0);
            end
            if (rst) begin
                sb.delete();
                modelCnt = 0;
            end else if (cmdValid && cmdReady) begin
                cmd_t c;
                c.start  = cyc;
                c.val    = cmdVal;
                c.expErr = (mode == 0) ? 1'b0 : (mode == 1) ? (cmdVal == 1'b1) : 1'b1;
                sb.push_back(c);
            end
        end
    end

    always @(negedge clk) begin
        if (monOn) assert (!(s && r)) else $error("[TB] s and r both high");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        monOn = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Set, reset, and a repeated reset that must still run the whole sequence.
        sendCmd(1'b1, 1'b0);
        waitIdle();
        sendCmd(1'b0, 1'b0);
        waitIdle();
        sendCmd(1'b0, 1'b0);
        waitIdle();

        // Back-to-back commands with cmd_valid held and cmd_val alternating.
        sendCmd(1'b1, 1'b1);
        sendCmd(1'b0, 1'b1);
        sendCmd(1'b1, 1'b0);
        waitIdle();

        // Invalid latch readback flags an error for either command value.
        mode = 2;
        sendCmd(1'b1, 1'b0);
        waitIdle();
        sendCmd(1'b0, 1'b0);
        waitIdle();
        mode = 0;

        // Reset asserted in cycle 4 of a command aborts it.
        sendCmd(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitIdle();

        // Stuck latch: enough failing commands to saturate the counter.
        mode = 1;
        for (int i = 0; i < 300; i++) begin
            sendCmd(1'b1, (i < 299) ? 1'b1 : 1'b0);
        end
        waitIdle();
        checkOutput("errCntSaturated", 32'(errCnt), 32'd255);
        checkOutput("scoreboardDrained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
